// File: rtl/mod_ctrl_pkg.sv
// Purpose : shared state encoding, default parameters and target clamp helper for the ramp controller.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package mod_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RAMP   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RAMPDN = 3'd4,
    ST_FAULT  = 3'd5
  } ramp_state_t;

  localparam logic signed [15:0] DEF_LIMIT      = 16'sd30000;
  localparam int unsigned        DEF_SETTLE_CYC = 16;

  // Clamp a requested modulation index into -lim..+lim. Compared in 17 bits so
  // that -32768 against a negated limit cannot overflow.
  function automatic logic signed [15:0] clamp_tgt(input logic signed [15:0] t,
                                                   input logic signed [15:0] lim);
    logic signed [16:0] t17;
    logic signed [16:0] l17;
    t17 = {t[15], t};
    l17 = {lim[15], lim};
    if (t17 > l17) begin
      return lim;
    end else if (t17 < -l17) begin
      return 16'(-l17);
    end
    return t;
  endfunction

endpackage

// File: rtl/mod_ramp_step.sv
// Purpose : one saturating step of cur toward goal by step (step=0 behaves as 1).
// Latency : combinational, zero cycles.
// Backpressure : none.
// Ports   : cur/goal signed 16, step unsigned 16 -> nxt signed 16, done (nxt == goal).
module mod_ramp_step
  import mod_ctrl_pkg::*;
(
  input  logic signed [15:0] cur,
  input  logic signed [15:0] goal,
  input  logic        [15:0] step,
  output logic signed [15:0] nxt,
  output logic               done
);

  logic signed [16:0] diff;
  logic        [16:0] mag;
  logic        [16:0] stp;

  always_comb begin
    stp  = (step == 16'd0) ? 17'd1 : {1'b0, step};
    // 17-bit difference covers the full span between two 16-bit values.
    diff = {goal[15], goal} - {cur[15], cur};
    mag  = diff[16] ? 17'(-diff) : 17'(diff);
    done = (mag <= stp);
    // When not done, |diff| > step, so cur +/- step lies strictly between cur
    // and goal and cannot leave the 16-bit range.
    if (done) begin
      nxt = goal;
    end else if (diff[16]) begin
      nxt = cur - stp[15:0];
    end else begin
      nxt = cur + stp[15:0];
    end
  end

endmodule

// File: rtl/mod_ramp_ctrl.sv
// Purpose : modulator enable/ramp sequencer (IDLE, SETTLE, RAMP, HOLD, RAMPDN, FAULT).
// Latency : all outputs registered; one clk from event to output change.
// Backpressure : none; every input is sampled each clk, pulses must be one cycle wide.
// Ports   : clk, rst (async active-low); start/stop/target_ld/clear pulses, fault level,
//           tick rate strobe, target (signed) and step (unsigned) data;
//           mod_en, mod, at_target, state outputs to the modulator and debug.
module mod_ramp_ctrl
  import mod_ctrl_pkg::*;
#(
  parameter logic signed [15:0] LIMIT      = DEF_LIMIT,
  parameter int unsigned        SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               target_ld,
  input  logic signed [15:0] target,
  input  logic        [15:0] step,
  input  logic               tick,
  input  logic               fault,
  input  logic               clear,
  output logic               mod_en,
  output logic signed [15:0] mod,
  output logic               at_target,
  output logic        [2:0]  state
);

  ramp_state_t        state_q;
  logic signed [15:0] tgt_q;
  logic        [15:0] settle_cnt;
  logic signed [15:0] tgt_in;
  logic signed [15:0] goal;
  logic signed [15:0] step_nxt;
  logic               step_done;
  logic               settle_last;

  assign state       = state_q;
  assign tgt_in      = clamp_tgt(target, LIMIT);
  // A single stepper serves both directions: ramp-down simply aims at zero.
  assign goal        = (state_q == ST_RAMPDN) ? 16'sd0 : tgt_q;
  assign settle_last = ((32'(settle_cnt) + 32'd1) >= SETTLE_CYC);

  mod_ramp_step u_step (
    .cur  (mod),
    .goal (goal),
    .step (step),
    .nxt  (step_nxt),
    .done (step_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mod_en     <= 1'b0;
      mod        <= '0;
      at_target  <= 1'b0;
      tgt_q      <= '0;
      settle_cnt <= '0;
    end else if (fault) begin
      state_q    <= ST_FAULT;
      mod_en     <= 1'b0;
      mod        <= '0;
      at_target  <= 1'b0;
      settle_cnt <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // stop outranks start, so a simultaneous pair leaves us idle.
          if (!stop) begin
            if (start) begin
              state_q    <= ST_SETTLE;
              tgt_q      <= tgt_in;
              mod_en     <= 1'b1;
              settle_cnt <= '0;
            end else if (target_ld) begin
              tgt_q <= tgt_in;
            end
          end
        end
        ST_SETTLE: begin
          if (stop) begin
            state_q <= ST_RAMPDN;
          end else begin
            if (target_ld) begin
              tgt_q <= tgt_in;
            end
            if (settle_last) begin
              state_q <= ST_RAMP;
            end else begin
              settle_cnt <= settle_cnt + 16'd1;
            end
          end
        end
        ST_RAMP: begin
          if (stop) begin
            state_q   <= ST_RAMPDN;
            at_target <= 1'b0;
          end else if (target_ld) begin
            tgt_q <= tgt_in;
          end else if (tick) begin
            mod <= step_nxt;
            if (step_done) begin
              state_q   <= ST_HOLD;
              at_target <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (stop) begin
            state_q   <= ST_RAMPDN;
            at_target <= 1'b0;
          end else if (target_ld) begin
            tgt_q <= tgt_in;
            if (tgt_in != mod) begin
              state_q   <= ST_RAMP;
              at_target <= 1'b0;
            end
          end
        end
        ST_RAMPDN: begin
          // Already at zero (stopped during settle): nothing left to ramp.
          if (mod == 16'sd0) begin
            state_q <= ST_IDLE;
            mod_en  <= 1'b0;
          end else if (tick) begin
            mod <= step_nxt;
            if (step_done) begin
              state_q <= ST_IDLE;
              mod_en  <= 1'b0;
            end
          end
        end
        ST_FAULT: begin
          // fault is known low here; the fault branch above holds us otherwise.
          if (clear) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mod_en    <= 1'b0;
          mod       <= '0;
          at_target <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_ramp_ctrl.sv
module tb_mod_ramp_ctrl;

  localparam int LIM  = 30000;
  localparam int SCYC = 16;
  localparam int S_IDLE = 0, S_SETTLE = 1, S_RAMP = 2, S_HOLD = 3, S_RAMPDN = 4, S_FAULT = 5;

  logic               clk, rst, start, stop, target_ld, tick, fault, clear;
  logic signed [15:0] target;
  logic        [15:0] step;
  logic               mod_en, at_target;
  logic signed [15:0] mod;
  logic        [2:0]  state;

  mod_ramp_ctrl #(.LIMIT(16'sd30000), .SETTLE_CYC(SCYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .target_ld (target_ld),
    .target    (target),
    .step      (step),
    .tick      (tick),
    .fault     (fault),
    .clear     (clear),
    .mod_en    (mod_en),
    .mod       (mod),
    .at_target (at_target),
    .state     (state)
  );

  typedef struct { bit en; int md; bit at; int st; } exp_t;
  typedef struct { string nm; int sel; int val; } dchk_t;

  exp_t  exp_q[$];
  dchk_t dq[$];
  int    checks = 0;
  int    errors = 0;
  bit    done = 0;
  int    ncyc = 0;

  // Reference model state (behavioural, spec-level quantities).
  int m_st, m_mod, m_tgt, m_left;
  bit m_en, m_at;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int clampv(input int t);
    if (t > LIM) return LIM;
    if (t < -LIM) return -LIM;
    return t;
  endfunction

  function automatic int toward(input int cur, input int goal, input int s_in);
    int s, d, a;
    s = (s_in == 0) ? 1 : s_in;
    d = goal - cur;
    a = (d < 0) ? -d : d;
    if (a <= s) return goal;
    return (d > 0) ? cur + s : cur - s;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_mod = 0; m_tgt = 0; m_left = 0; m_en = 0; m_at = 0;
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.en = m_en; e.md = m_mod; e.at = m_at; e.st = m_st;
    return e;
  endfunction

  task automatic model_step();
    int t, s;
    t = target;
    s = step;
    if (!rst) begin
      model_reset();
    end else if (fault) begin
      m_st = S_FAULT; m_en = 0; m_mod = 0; m_at = 0;
    end else begin
      case (m_st)
        S_IDLE: if (!stop) begin
          if (start) begin
            m_tgt = clampv(t); m_st = S_SETTLE; m_en = 1; m_left = SCYC;
          end else if (target_ld) begin
            m_tgt = clampv(t);
          end
        end
        S_SETTLE: if (stop) m_st = S_RAMPDN;
        else begin
          if (target_ld) m_tgt = clampv(t);
          m_left = m_left - 1;
          if (m_left == 0) m_st = S_RAMP;
        end
        S_RAMP: if (stop) begin
          m_st = S_RAMPDN; m_at = 0;
        end else if (target_ld) begin
          m_tgt = clampv(t);
        end else if (tick) begin
          m_mod = toward(m_mod, m_tgt, s);
          if (m_mod == m_tgt) begin m_st = S_HOLD; m_at = 1; end
        end
        S_HOLD: if (stop) begin
          m_st = S_RAMPDN; m_at = 0;
        end else if (target_ld) begin
          m_tgt = clampv(t);
          if (m_tgt != m_mod) begin m_st = S_RAMP; m_at = 0; end
        end
        S_RAMPDN: if (m_mod == 0) begin
          m_st = S_IDLE; m_en = 0;
        end else if (tick) begin
          m_mod = toward(m_mod, 0, s);
          if (m_mod == 0) begin m_st = S_IDLE; m_en = 0; end
        end
        S_FAULT: if (clear) m_st = S_IDLE;
        default: model_reset();
      endcase
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_step();
    exp_q.push_back(snap());
    #1;
    start = 0; stop = 0; target_ld = 0; clear = 0;
  endtask

  task automatic run(input int n);
    repeat (n) clk_cycle();
  endtask

  // sel: 0 mod_en, 1 mod, 2 at_target, 3 state
  task automatic expect_out(input string nm, input int sel, input int val);
    dchk_t d;
    d.nm = nm; d.sel = sel; d.val = val;
    dq.push_back(d);
  endtask

  task automatic wait_state(input int st, input int budget, input string nm);
    int n;
    n = 0;
    while (int'(state) != st && n < budget) begin
      clk_cycle();
      n++;
    end
    expect_out(nm, 3, st);
  endtask

  // Monitor: compares every registered output sample against the scoreboard.
  exp_t  me;
  dchk_t md;
  int    gm, got;
  always @(negedge clk) begin
    ncyc++;
    gm = mod;
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      checks++;
      if (mod_en !== me.en || gm != me.md || at_target !== me.at || int'(state) != me.st) begin
        errors++;
        $display("FAIL out@cycle%0d: got en=%0d mod=%0d at=%0d st=%0d, want en=%0d mod=%0d at=%0d st=%0d",
                 ncyc, mod_en, gm, at_target, state, me.en, me.md, me.at, me.st);
      end
    end
    while (dq.size() != 0) begin
      md = dq.pop_front();
      case (md.sel)
        0:       got = int'(mod_en);
        1:       got = gm;
        2:       got = int'(at_target);
        default: got = int'(state);
      endcase
      checks++;
      if (got != md.val) begin
        errors++;
        $display("FAIL %s: got %0d want %0d", md.nm, got, md.val);
      end
    end
    if (done || ncyc > 60000) begin
      checks++;
      if (ncyc > 60000 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL run_end: cycles=%0d pending=%0d want pending=0 within 60000", ncyc, exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    rst = 0; start = 0; stop = 0; target_ld = 0; tick = 0; fault = 0; clear = 0;
    target = 0; step = 0;
    model_reset();
    run(2);
    expect_out("rst_en", 0, 0);
    expect_out("rst_mod", 1, 0);
    expect_out("rst_at", 2, 0);
    expect_out("rst_state", 3, S_IDLE);
    rst = 1;

    // Basic ramp: target 100, step 30, tick every cycle.
    target = 100; step = 30; tick = 1; start = 1;
    clk_cycle();
    expect_out("start_en", 0, 1);
    expect_out("start_state", 3, S_SETTLE);
    run(SCYC - 1);
    expect_out("settle_len", 3, S_SETTLE);
    run(1);
    expect_out("settle_exit", 3, S_RAMP);
    expect_out("settle_mod", 1, 0);
    run(4);
    expect_out("ramp_mod", 1, 100);
    expect_out("ramp_at", 2, 1);
    expect_out("ramp_hold", 3, S_HOLD);

    // Ramp-down from 100 with step 40, tick every other cycle.
    stop = 1; step = 40; tick = 0;
    clk_cycle();
    expect_out("stop_state", 3, S_RAMPDN);
    for (int i = 0; i < 5; i++) begin
      tick = (i % 2 == 0);
      clk_cycle();
    end
    expect_out("dn_mod", 1, 0);
    expect_out("dn_en", 0, 0);
    expect_out("dn_state", 3, S_IDLE);

    // Clamp at +LIMIT, then retarget to -32768 (clamped to -LIMIT).
    target = 32000; step = 10000; tick = 1; start = 1;
    clk_cycle();
    run(SCYC + 3);
    expect_out("clamp_pos", 1, 30000);
    expect_out("clamp_hold", 3, S_HOLD);
    target = -32768; target_ld = 1;
    clk_cycle();
    expect_out("retgt_ramp", 3, S_RAMP);
    wait_state(S_HOLD, 20, "neg_hold");
    expect_out("clamp_neg", 1, -30000);
    stop = 1;
    clk_cycle();
    wait_state(S_IDLE, 20, "neg_idle");

    // step = 0 behaves as 1.
    target = -3; step = 0; tick = 1; start = 1;
    clk_cycle();
    run(SCYC + 1);
    expect_out("step0_a", 1, -1);
    run(1);
    expect_out("step0_b", 1, -2);
    run(1);
    expect_out("step0_c", 1, -3);
    expect_out("step0_hold", 3, S_HOLD);
    stop = 1;
    clk_cycle();
    wait_state(S_IDLE, 20, "step0_idle");

    // Fault beats stop; clear only honoured once fault drops.
    target = 1000; step = 10; tick = 1; start = 1;
    clk_cycle();
    run(SCYC + 5);
    fault = 1; stop = 1;
    clk_cycle();
    expect_out("fault_state", 3, S_FAULT);
    expect_out("fault_en", 0, 0);
    expect_out("fault_mod", 1, 0);
    clear = 1;
    clk_cycle();
    expect_out("clear_ignored", 3, S_FAULT);
    fault = 0;
    run(2);
    expect_out("fault_held", 3, S_FAULT);
    clear = 1;
    clk_cycle();
    expect_out("clear_idle", 3, S_IDLE);

    // Asynchronous reset between edges mid-ramp.
    target = 5000; step = 100; tick = 1; start = 1;
    clk_cycle();
    run(SCYC + 3);
    #2;
    rst = 0;
    model_reset();
    exp_q.delete();
    exp_q.push_back(snap());
    expect_out("arst_mod", 1, 0);
    expect_out("arst_en", 0, 0);
    expect_out("arst_state", 3, S_IDLE);
    clk_cycle();
    rst = 1;
    target = 200; step = 100; start = 1;
    clk_cycle();
    expect_out("restart_settle", 3, S_SETTLE);
    wait_state(S_HOLD, SCYC + 10, "restart_hold");
    target = 200; target_ld = 1;
    clk_cycle();
    expect_out("same_tgt_hold", 3, S_HOLD);
    target = 250; target_ld = 1;
    clk_cycle();
    expect_out("new_tgt_ramp", 3, S_RAMP);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      target_ld = ($urandom_range(0, 14) == 0);
      tick      = $urandom_range(0, 1);
      clear     = ($urandom_range(0, 7) == 0);
      if (fault) fault = ($urandom_range(0, 3) != 0);
      else       fault = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) step = 16'($urandom_range(0, 65535));
      else if ($urandom_range(0, 9) == 0) step = 16'($urandom_range(0, 2000));
      target = 16'($urandom);
      clk_cycle();
    end

    fault = 0; tick = 0;
    run(2);
    done = 1;
  end

endmodule

// File: doc/mod_ramp_ctrl.md
MOD_RAMP_CTRL -- requirements
Module: mod_ramp_ctrl

Interface
REQ-001 Parameter LIMIT, default 16'sd30000: magnitude clamp applied to every latched target (range -LIMIT..+LIMIT).
REQ-002 Parameter SETTLE_CYC, default 16: number of clk cycles modulator is enabled at mod=0 before ramping.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins enable/ramp sequence from IDLE.
REQ-006 stop  input  1  one-cycle pulse; ramps mod to 0, then disables modulator.
REQ-007 target_ld  input  1  one-cycle pulse; latches target (start also latches it).
REQ-008 target  input  16 signed  requested modulation index.
REQ-009 step  input  16 unsigned  ramp increment per tick; 0 treated as 1.
REQ-010 tick  input  1  ramp-rate strobe; mod changes only on cycles with tick=1.
REQ-011 fault  input  1  level; forces immediate shutdown.
REQ-012 clear  input  1  one-cycle pulse; leaves FAULT.
REQ-013 mod_en  output  1  drives modulator en.
REQ-014 mod  output  16 signed  drives modulator mod.
REQ-015 at_target  output  1  high in HOLD.
REQ-016 state  output  3  encoded state for debug.

Function
REQ-017 States: IDLE=0, SETTLE=1, RAMP=2, HOLD=3, RAMPDN=4, FAULT=5; all outputs registered.
REQ-018 IDLE: mod_en=0, mod=0; start -> SETTLE, target latched (clamped), mod_en=1 from next edge.
REQ-019 SETTLE: mod_en=1, mod=0; after exactly SETTLE_CYC cycles in SETTLE -> RAMP.
REQ-020 RAMP: on tick, mod moves toward latched target by step; if |tgt-mod| <= step, mod=tgt and -> HOLD same edge.
REQ-021 RAMP/HOLD: target_ld re-latches target (clamped); HOLD -> RAMP on next edge if mod != new target.
REQ-022 Difference/step arithmetic in 17-bit signed; mod never exceeds ±LIMIT and never wraps.
REQ-023 stop in SETTLE/RAMP/HOLD -> RAMPDN; RAMPDN moves mod toward 0 by step per tick; on reaching 0 -> IDLE, mod_en=0 on that same edge.
REQ-024 start and target_ld ignored in RAMPDN and FAULT; start ignored outside IDLE.
REQ-025 fault=1 in any state -> FAULT next edge with mod_en=0, mod=0.
REQ-026 FAULT: held while fault=1; clear with fault=0 -> IDLE; clear with fault=1 ignored.
REQ-027 Priority for simultaneous events: fault > stop > start/target_ld > tick.
REQ-028 stop and start together in IDLE: remain IDLE.

Reset
REQ-029 rst=0 asynchronously forces IDLE, mod_en=0, mod=0, at_target=0, latched target=0, settle counter=0, regardless of clk.
REQ-030 Reset mid-ramp discards all state; first start after release restarts from SETTLE.

Structure
REQ-031 State encoding constants and default LIMIT/SETTLE_CYC belong in shared package mod_ctrl_pkg.
REQ-032 One sub-module: mod_ramp_step (combinational saturating step-toward-value: current, goal, step -> next), reused for RAMP and RAMPDN.

Verification
REQ-033 Reset, start with target=100, step=30, tick every cycle -> mod_en=1 after 1 cycle, mod=0 for 16 cycles, then 30,60,90,100, at_target=1.
REQ-034 target=32000, LIMIT=30000, step=10000 -> mod 10000,20000,30000, HOLD at 30000; target=-32768 ramps down to -30000 without wrap.
REQ-035 HOLD at 100, stop, step=40, tick every 2 cycles -> mod 60,20,0 on tick edges; mod_en=0 on edge mod reaches 0; state=IDLE.
REQ-036 fault asserted mid-RAMP with stop same cycle -> FAULT next edge, mod_en=0, mod=0; clear while fault=1 ignored; fault=0 then clear -> IDLE.
REQ-037 step=0, target=-3 -> mod -1,-2,-3 on successive ticks.
REQ-038 rst=0 asserted between clk edges during RAMP -> outputs zero immediately, state=IDLE.
